// File: rtl/inst_rom_arbiter.sv
// inst_rom_arbiter: grants the single-ported instruction ROM to the fetch or secondary port and sequences wait cycles.
// Define INST_ARB_RR_EN to replace secondary priority plus the starvation limit with a one-bit round-robin pointer.
module inst_rom_arbiter #(
    parameter int unsigned WAIT_CYCLES  = 0,
    parameter int unsigned STARVE_LIMIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_ack,
    output logic [31:0] f_inst,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    output logic        d_ack,
    output logic [31:0] d_data,
    output logic        err,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    output logic        stall_req
);
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned CNT_W    = 4;
`ifndef INST_ARB_RR_EN
    localparam int unsigned STARVE_W = 3;
`endif

    typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                owner_f_q, owner_f_d;
    logic                f_ack_d, d_ack_d, err_d, rom_ce_d;
    logic [DATA_W-1:0]   f_inst_d, d_data_d, rom_addr_d;
    logic                f_vld, d_vld, gnt_f, gnt_d;
    logic [DATA_W-1:0]   gnt_addr;
`ifdef INST_ARB_RR_EN
    logic                ptr_f_q, ptr_f_d;
`else
    logic [STARVE_W-1:0] starve_q, starve_d;
`endif

    assign stall_req = f_req & ~f_ack;

    // A requester whose ack is high this cycle is not re-granted on a still-held request
    assign f_vld = f_req & ~f_ack;
    assign d_vld = d_req & ~d_ack;

    always_comb begin
        gnt_f = 1'b0;
        gnt_d = 1'b0;
`ifdef INST_ARB_RR_EN
        ptr_f_d = ptr_f_q;
        if (state_q == S_IDLE) begin
            if (f_vld && d_vld) begin
                gnt_f   = ptr_f_q;
                gnt_d   = ~ptr_f_q;
                ptr_f_d = ~ptr_f_q;
            end else begin
                gnt_f = f_vld;
                gnt_d = d_vld;
            end
        end
`else
        starve_d = starve_q;
        if (state_q == S_IDLE) begin
            if (f_vld && d_vld) begin
                gnt_f = (starve_q == STARVE_W'(STARVE_LIMIT));
                gnt_d = ~gnt_f;
            end else begin
                gnt_f = f_vld;
                gnt_d = d_vld;
            end
            // Count consecutive secondary grants taken while fetch was waiting
            if (gnt_f) begin
                starve_d = '0;
            end else if (gnt_d) begin
                if (!f_req) begin
                    starve_d = '0;
                end else if (starve_q != STARVE_W'(STARVE_LIMIT)) begin
                    starve_d = starve_q + STARVE_W'(1);
                end
            end
        end
`endif
        gnt_addr = gnt_f ? f_addr : d_addr;
    end

    // Access sequencer: next-state and next-output values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_f_d  = owner_f_q;
        f_ack_d    = 1'b0;
        d_ack_d    = 1'b0;
        err_d      = 1'b0;
        f_inst_d   = f_inst;
        d_data_d   = d_data;
        rom_ce_d   = rom_ce;
        rom_addr_d = rom_addr;
        case (state_q)
            S_IDLE: begin
                if (gnt_f || gnt_d) begin
                    if (gnt_addr[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        f_ack_d = gnt_f;
                        d_ack_d = gnt_d;
                        if (gnt_f) begin
                            f_inst_d = '0;
                        end else begin
                            d_data_d = '0;
                        end
                    end else begin
                        state_d    = S_ACCESS;
                        owner_f_d  = gnt_f;
                        cnt_d      = CNT_W'(WAIT_CYCLES);
                        rom_ce_d   = 1'b1;
                        rom_addr_d = gnt_addr;
                    end
                end
            end
            S_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d    = S_IDLE;
                    rom_ce_d   = 1'b0;
                    rom_addr_d = '0;
                    f_ack_d    = owner_f_q;
                    d_ack_d    = ~owner_f_q;
                    if (owner_f_q) begin
                        f_inst_d = rom_inst;
                    end else begin
                        d_data_d = rom_inst;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            owner_f_q <= 1'b0;
            f_ack     <= 1'b0;
            d_ack     <= 1'b0;
            err       <= 1'b0;
            f_inst    <= '0;
            d_data    <= '0;
            rom_ce    <= 1'b0;
            rom_addr  <= '0;
`ifdef INST_ARB_RR_EN
            ptr_f_q   <= 1'b1;
`else
            starve_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_f_q <= owner_f_d;
            f_ack     <= f_ack_d;
            d_ack     <= d_ack_d;
            err       <= err_d;
            f_inst    <= f_inst_d;
            d_data    <= d_data_d;
            rom_ce    <= rom_ce_d;
            rom_addr  <= rom_addr_d;
`ifdef INST_ARB_RR_EN
            ptr_f_q   <= ptr_f_d;
`else
            starve_q  <= starve_d;
`endif
        end
    end

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Bench for inst_rom_arbiter: instance 0 runs WAIT_CYCLES=0, instance 1 runs WAIT_CYCLES=3.
// Expected acks are queued when requests are driven and checked in order as acks appear.
module tb_inst_rom_arbiter;
    typedef struct packed {
        logic        port_f;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req     [2];
    logic        d_req     [2];
    logic [31:0] f_addr    [2];
    logic [31:0] d_addr    [2];
    logic [31:0] rom_inst  [2];
    logic        f_ack     [2];
    logic        d_ack     [2];
    logic        err       [2];
    logic        rom_ce    [2];
    logic        stall_req [2];
    logic [31:0] f_inst    [2];
    logic [31:0] d_data    [2];
    logic [31:0] rom_addr  [2];
    logic [31:0] rom       [16];

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 2; i++) begin : g_dut
        inst_rom_arbiter #(
            .WAIT_CYCLES (i * 3),
            .STARVE_LIMIT(2)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .f_req    (f_req[i]),
            .f_addr   (f_addr[i]),
            .f_ack    (f_ack[i]),
            .f_inst   (f_inst[i]),
            .d_req    (d_req[i]),
            .d_addr   (d_addr[i]),
            .d_ack    (d_ack[i]),
            .d_data   (d_data[i]),
            .err      (err[i]),
            .rom_ce   (rom_ce[i]),
            .rom_addr (rom_addr[i]),
            .rom_inst (rom_inst[i]),
            .stall_req(stall_req[i])
        );
        assign rom_inst[i] = rom[rom_addr[i][5:2]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        if (a[1:0] != 2'b00) return 32'h0;
        return rom[a[5:2]];
    endfunction

    task automatic push(input logic pf, input logic [31:0] a);
        exp_t e;
        e.port_f = pf;
        e.err    = (a[1:0] != 2'b00);
        e.data   = exp_word(a);
        sb.push_back(e);
    endtask

    // Scoreboard: every ack must match the oldest outstanding expectation
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (f_ack[i] || d_ack[i]) begin
                check($sformatf("u%0d_ack_excl", i), 32'(f_ack[i] & d_ack[i]), 32'd0);
                if (sb.size() == 0) begin
                    check($sformatf("u%0d_unexpected_ack", i), 32'({f_ack[i], d_ack[i]}), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check($sformatf("u%0d_ack_port", i), 32'(f_ack[i]), 32'(e.port_f));
                    check($sformatf("u%0d_ack_data", i), f_ack[i] ? f_inst[i] : d_data[i], e.data);
                    check($sformatf("u%0d_ack_err", i), 32'(err[i]), 32'(e.err));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic single(input int i, input logic pf, input logic [31:0] a);
        int cyc  = 0;
        bit seen = 1'b0;
        push(pf, a);
        @(posedge clk); #1;
        if (pf) begin f_addr[i] = a; f_req[i] = 1'b1; end
        else    begin d_addr[i] = a; d_req[i] = 1'b1; end
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            seen = pf ? f_ack[i] : d_ack[i];
        end
        check("single_done", 32'(seen), 32'd1);
        f_req[i] = 1'b0;
        d_req[i] = 1'b0;
    endtask

    // Both ports request until `total` acks; in starve mode fetch withdraws during secondary ack cycles
    task automatic run_both(input int i, input int total, input bit starve_mode);
        int acks = 0;
        int cyc  = 0;
        bit f_on = 1'b1;
        bit d_on = 1'b1;
        while (acks < total && cyc < 200) begin
            @(posedge clk); #1;
            f_req[i] = f_on & ~(starve_mode & d_ack[i]);
            d_req[i] = d_on;
            @(negedge clk);
            cyc++;
            if (f_ack[i] || d_ack[i]) begin
                acks++;
                if (acks >= total - 1) begin
                    if (f_ack[i]) f_on = 1'b0;
                    else          d_on = 1'b0;
                end
            end
        end
        check("run_done", 32'(acks), 32'(total));
        f_req[i] = 1'b0;
        d_req[i] = 1'b0;
        idle(5);
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        for (int k = 0; k < 16; k++) rom[k] = 32'hC0DE_0000 | 32'(k * 32'h0101);
        rom[2] = 32'h3401_1100;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            f_req[i] = 1'b0; d_req[i] = 1'b0; f_addr[i] = '0; d_addr[i] = '0;
        end
        idle(2);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d_rst_f_ack", i), 32'(f_ack[i]), 32'd0);
            check($sformatf("u%0d_rst_d_ack", i), 32'(d_ack[i]), 32'd0);
            check($sformatf("u%0d_rst_err", i), 32'(err[i]), 32'd0);
            check($sformatf("u%0d_rst_rom_ce", i), 32'(rom_ce[i]), 32'd0);
            check($sformatf("u%0d_rst_rom_addr", i), rom_addr[i], 32'd0);
            check($sformatf("u%0d_rst_f_inst", i), f_inst[i], 32'd0);
            check($sformatf("u%0d_rst_d_data", i), d_data[i], 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        idle(2);

        // Fetch of word 2 with no wait cycles
        push(1'b1, 32'h8);
        @(posedge clk); #1;
        f_addr[0] = 32'h8; f_req[0] = 1'b1;
        for (int c = 0; c <= 2; c++) begin
            @(negedge clk);
            check($sformatf("t1_rom_ce_c%0d", c), 32'(rom_ce[0]), 32'(c == 1));
            check($sformatf("t1_rom_addr_c%0d", c), rom_addr[0], (c == 1) ? 32'h8 : 32'h0);
            check($sformatf("t1_stall_c%0d", c), 32'(stall_req[0]), 32'(c < 2));
            check($sformatf("t1_f_ack_c%0d", c), 32'(f_ack[0]), 32'(c == 2));
        end
        f_req[0] = 1'b0;
        idle(3);

        // Secondary read with three wait cycles
        push(1'b0, 32'h4);
        @(posedge clk); #1;
        d_addr[1] = 32'h4; d_req[1] = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("t2_rom_ce_c%0d", c), 32'(rom_ce[1]), 32'(c >= 1 && c <= 4));
            check($sformatf("t2_rom_addr_c%0d", c), rom_addr[1], (c >= 1 && c <= 4) ? 32'h4 : 32'h0);
            check($sformatf("t2_d_ack_c%0d", c), 32'(d_ack[1]), 32'(c == 5));
        end
        d_req[1] = 1'b0;
        idle(3);

        // Misaligned fetch: immediate error ack, no ROM access
        push(1'b1, 32'h6);
        @(posedge clk); #1;
        f_addr[0] = 32'h6; f_req[0] = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("t3_rom_ce_c%0d", c), 32'(rom_ce[0]), 32'd0);
            check($sformatf("t3_f_ack_c%0d", c), 32'(f_ack[0]), 32'(c == 1));
            check($sformatf("t3_err_c%0d", c), 32'(err[0]), 32'(c == 1));
            if (c == 1) f_req[0] = 1'b0;
        end
        idle(2);

        // Both ports requesting continuously
        f_addr[0] = 32'h10; d_addr[0] = 32'h14;
`ifdef INST_ARB_RR_EN
        push(1'b1, 32'h10); push(1'b0, 32'h14); push(1'b1, 32'h10); push(1'b0, 32'h14);
`else
        push(1'b0, 32'h14); push(1'b1, 32'h10); push(1'b0, 32'h14); push(1'b1, 32'h10);
`endif
        run_both(0, 4, 1'b0);

`ifndef INST_ARB_RR_EN
        // Starvation limit: two secondary grants against a waiting fetch, then fetch
        f_addr[0] = 32'h20; d_addr[0] = 32'h24;
        push(1'b0, 32'h24); push(1'b0, 32'h24); push(1'b1, 32'h20);
        push(1'b0, 32'h24); push(1'b0, 32'h24); push(1'b1, 32'h20);
        run_both(0, 6, 1'b1);
`endif

        // Reset during an access aborts it
        @(posedge clk); #1;
        f_addr[1] = 32'h8; f_req[1] = 1'b1;
        @(posedge clk); #1;
        check("t6_rom_ce_before", 32'(rom_ce[1]), 32'd1);
        rst = 1'b0;
        f_req[1] = 1'b0;
        @(negedge clk);
        check("t6_rst_rom_ce", 32'(rom_ce[1]), 32'd0);
        check("t6_rst_rom_addr", rom_addr[1], 32'd0);
        check("t6_rst_f_ack", 32'(f_ack[1]), 32'd0);
        check("t6_rst_err", 32'(err[1]), 32'd0);
        check("t6_rst_d_data", d_data[1], 32'd0);
        check("t6_rst_f_inst", f_inst[1], 32'd0);
        check("t6_rst_stall", 32'(stall_req[1]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("t6_quiet_ce_c%0d", c), 32'(rom_ce[1]), 32'd0);
            check($sformatf("t6_quiet_ack_c%0d", c), 32'(f_ack[1] | d_ack[1]), 32'd0);
        end
        single(1, 1'b0, 32'hC);
        idle(3);
        check("final_sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
